pipe_stage_reg: RTL and testbench

//  Generic, parametrised inter-stage pipeline register for the 5-stage CPU.

---
 rtl/pipe_stage_reg_pkg.sv | 21 ++
 rtl/pipe_skid_buf.sv | 62 ++++++
 rtl/pipe_stage_reg.sv | 96 +++++++++
 tb/tb_pipe_stage_reg.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: constants shared by the inter-stage registers.
// Holds stall levels, reset level, stage indices and mode selects.
package pipe_stage_reg_pkg;

    localparam logic STOP      = 1'b1;
    localparam logic NOSTOP    = 1'b0;
    localparam logic RstEnable = 1'b1;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int MODE_STALL = 0;
    localparam int MODE_SKID  = 1;

    // addi x0,x0,0 : the bubble instruction word
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: main + skid register pair with valid/ready handshake.
// Ports: clk, rst, flush, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module pipe_skid_buf
    import pipe_stage_reg_pkg::*;
#(
    parameter int               DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              main_v;
    logic              skid_v;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_d;
    logic              up;
    logic              dn;

    // ready depends only on state, so out_ready never reaches in_ready
    assign up = in_valid && !skid_v;
    assign dn = main_v && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= NOP_VALUE;
            skid_d <= NOP_VALUE;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= NOP_VALUE;
            skid_d <= NOP_VALUE;
        end else if (skid_v) begin
            // upstream is blocked while skid is full
            if (dn) begin
                main_d <= skid_d;
                skid_v <= 1'b0;
                skid_d <= NOP_VALUE;
            end
        end else if (!main_v || dn) begin
            main_v <= up;
            main_d <= up ? in_data : NOP_VALUE;
        end else if (up) begin
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end

    assign in_ready  = !rst && !skid_v;
    assign out_valid = main_v;
    assign out_data  = main_d;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register with perf counter.
// Ports: clk, rst, stall, flush, in_*/out_* handshake, stall_cnt.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int               DATA_W    = 64,
    parameter int               STALL_W   = 6,
    parameter int               STAGE_IDX = STG_EX,
    parameter int               MODE      = MODE_STALL,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int               CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [CNT_W-1:0]   stall_cnt
);

    // a valid output is being held back this edge
    logic held;

    generate
        if (MODE == MODE_STALL) begin : g_stall
            logic              us_stall;
            logic              ds_stall;
            logic              v_q;
            logic [DATA_W-1:0] d_q;
            logic              unused_mode;

            assign unused_mode = ^{out_ready, stall};
            assign us_stall    = (stall[STAGE_IDX] == STOP);

            // the last stage has nobody downstream to stall it
            if (STAGE_IDX == STALL_W-1) begin : g_last
                assign ds_stall = NOSTOP;
            end else begin : g_mid
                assign ds_stall = stall[STAGE_IDX+1];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst == RstEnable) begin
                    v_q <= 1'b0;
                    d_q <= NOP_VALUE;
                end else if (flush || (us_stall && !ds_stall)) begin
                    v_q <= 1'b0;
                    d_q <= NOP_VALUE;
                end else if (!us_stall) begin
                    v_q <= in_valid;
                    d_q <= in_valid ? in_data : NOP_VALUE;
                end
            end

            assign in_ready  = !rst && !us_stall;
            assign out_valid = v_q;
            assign out_data  = d_q;
            assign held      = v_q && ds_stall;
        end else begin : g_skid
            logic unused_mode;

            assign unused_mode = ^stall;

            pipe_skid_buf #(
                .DATA_W    (DATA_W),
                .NOP_VALUE (NOP_VALUE)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   (in_data),
                .out_valid (out_valid),
                .out_ready (out_ready),
                .out_data  (out_data)
            );

            assign held = out_valid && !out_ready;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            stall_cnt <= '0;
        end else if (held && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed bench for pipe_stage_reg.
// Three instances: stall mode (mid and last stage) and skid mode.
module tb_pipe_stage_reg;

    localparam logic [63:0] NOP0 = 64'h0;
    localparam logic [63:0] NOP2 = 64'h13;
    localparam logic [31:0] NOP1 = 32'h13;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush0;
    logic        iv0;
    logic [63:0] idata0;
    logic        ir0, ov0, ir2, ov2;
    logic [63:0] od0, od2;
    logic [3:0]  cnt0;
    logic [15:0] cnt2;

    logic        flush1;
    logic        iv1;
    logic        or1;
    logic [31:0] idata1;
    logic        ir1, ov1;
    logic [31:0] od1;
    logic [15:0] cnt1;

    int n_checks;
    int n_errors;

    // reference state
    logic        mv0, mv2;
    logic [63:0] md0, md2;
    int          mc0, mc2, mc1;
    logic [31:0] q[$];

    logic        pre_ir1, pre_ov1;
    logic [31:0] pre_od1;

    pipe_stage_reg #(
        .STAGE_IDX (2),
        .MODE      (0),
        .NOP_VALUE (NOP0),
        .CNT_W     (4)
    ) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush0),
        .in_valid  (iv0),
        .in_ready  (ir0),
        .in_data   (idata0),
        .out_valid (ov0),
        .out_ready (1'b1),
        .out_data  (od0),
        .stall_cnt (cnt0)
    );

    pipe_stage_reg #(
        .STAGE_IDX (5),
        .MODE      (0),
        .NOP_VALUE (NOP2),
        .CNT_W     (16)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush0),
        .in_valid  (iv0),
        .in_ready  (ir2),
        .in_data   (idata0),
        .out_valid (ov2),
        .out_ready (1'b1),
        .out_data  (od2),
        .stall_cnt (cnt2)
    );

    pipe_stage_reg #(
        .DATA_W    (32),
        .MODE      (1),
        .NOP_VALUE (NOP1),
        .CNT_W     (16)
    ) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush1),
        .in_valid  (iv1),
        .in_ready  (ir1),
        .in_data   (idata1),
        .out_valid (ov1),
        .out_ready (or1),
        .out_data  (od1),
        .stall_cnt (cnt1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // stall-mode rules: flush, bubble, load, hold
    function automatic void m0_eval(input int idx,
                                    input logic v,
                                    input logic [63:0] d,
                                    input int c,
                                    input int cmax,
                                    input logic [63:0] nop,
                                    output logic nv,
                                    output logic [63:0] nd,
                                    output int nc);
        logic [6:0] sx;
        logic us, ds;
        sx = {1'b0, stall};
        us = sx[idx];
        ds = sx[idx+1];
        nc = (v && ds && !flush0 && c < cmax) ? c + 1 : c;
        if (flush0 || (us && !ds)) begin
            nv = 1'b0;
            nd = nop;
        end else if (!us) begin
            nv = iv0;
            nd = iv0 ? idata0 : nop;
        end else begin
            nv = v;
            nd = d;
        end
    endfunction

    task automatic model_reset();
        mv0 = 1'b0; md0 = NOP0; mc0 = 0;
        mv2 = 1'b0; md2 = NOP2; mc2 = 0;
        mc1 = 0;
        q.delete();
    endtask

    task automatic model_edge();
        logic nv;
        logic [63:0] nd;
        int nc;
        logic up, dn;
        m0_eval(2, mv0, md0, mc0, 15, NOP0, nv, nd, nc);
        mv0 = nv; md0 = nd; mc0 = nc;
        m0_eval(5, mv2, md2, mc2, 65535, NOP2, nv, nd, nc);
        mv2 = nv; md2 = nd; mc2 = nc;
        // skid mode is a 2-deep FIFO
        up = iv1 && (q.size() < 2);
        dn = (q.size() > 0) && or1;
        if (q.size() > 0 && !or1 && !flush1 && mc1 < 65535) mc1++;
        if (flush1) begin
            q.delete();
        end else begin
            if (dn) void'(q.pop_front());
            if (up) q.push_back(idata1);
        end
    endtask

    task automatic check_outputs();
        check("ov0", ov0, mv0);
        check("od0", od0, md0);
        check("cnt0", cnt0, mc0);
        check("ov2", ov2, mv2);
        check("od2", od2, md2);
        check("cnt2", cnt2, mc2);
        check("ov1", ov1, q.size() > 0);
        check("od1", od1, (q.size() > 0) ? q[0] : NOP1);
        check("cnt1", cnt1, mc1);
    endtask

    task automatic cycle();
        #1;
        check("ir0", ir0, !stall[2]);
        check("ir2", ir2, !stall[5]);
        check("ir1", ir1, q.size() < 2);
        pre_ir1 = ir1;
        pre_ov1 = ov1;
        pre_od1 = od1;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic rand_inputs(input int flush_on);
        stall  = 6'($urandom);
        flush0 = flush_on != 0 && ($urandom % 8 == 0);
        iv0    = 1'($urandom);
        idata0 = {$urandom, $urandom};
        flush1 = flush_on != 0 && ($urandom % 10 == 0);
        iv1    = ($urandom % 4) != 0;
        or1    = ($urandom % 3) != 0;
        idata1 = $urandom;
    endtask

    initial begin
        int item;
        logic [31:0] got[$];
        n_checks = 0;
        n_errors = 0;
        clk = 1'b0;
        rst = 1'b1;
        stall = '0; flush0 = 0; iv0 = 0; idata0 = '0;
        flush1 = 0; iv1 = 0; or1 = 1; idata1 = '0;
        model_reset();
        #2;
        check_outputs();
        check("rst_ir0", ir0, 1'b0);
        check("rst_ir1", ir1, 1'b0);
        #10;
        rst = 1'b0;

        // warm-up traffic
        repeat (20) begin
            rand_inputs(1);
            cycle();
        end

        // T1: async reset with valid outputs
        stall = '0; flush0 = 0; iv0 = 1; idata0 = 64'hC0FFEE;
        flush1 = 0; iv1 = 1; or1 = 0; idata1 = 32'h77;
        cycle();
        check("t1_pre_ov0", ov0, 1'b1);
        check("t1_pre_ov1", ov1, 1'b1);
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("t1_ir0", ir0, 1'b0);
        check("t1_ir1", ir1, 1'b0);
        #10;
        check_outputs();
        iv0 = 0; iv1 = 0; or1 = 1;
        rst = 1'b0;
        #1;
        check("t1_rel_ir0", ir0, 1'b1);
        check("t1_rel_ir1", ir1, 1'b1);

        // T2: bubble when upstream stalled, downstream free
        stall = 6'b000000; iv0 = 1; idata0 = 64'h55;
        cycle();
        stall = 6'b000111; idata0 = 64'hA5;
        cycle();
        check("t2_ov", ov0, 1'b0);
        check("t2_od", od0, NOP0);

        // T3: hold when both stalled
        stall = 6'b000000; idata0 = 64'h1234;
        cycle();
        stall = 6'b001111;
        repeat (3) cycle();
        check("t3_od", od0, 64'h1234);
        check("t3_cnt", cnt0, 4'd3);

        // T4: flush beats load
        stall = 6'b000000; flush0 = 1; iv0 = 1; idata0 = 64'h99;
        cycle();
        check("t4_ov", ov0, 1'b0);
        flush0 = 0;

        // counter saturation on the 4-bit instance
        idata0 = 64'hBEEF;
        cycle();
        stall = 6'b001111;
        repeat (20) cycle();
        check("sat_cnt", cnt0, 4'hF);
        stall = '0; iv0 = 0;
        cycle();

        // T5: stream 0..9, downstream blocked on cycles 3-5
        item = 0;
        for (int c = 0; c < 40 && got.size() < 10; c++) begin
            or1 = !(c >= 3 && c <= 5);
            iv1 = item < 10;
            idata1 = item;
            cycle();
            if (c == 4) check("t5_ready_low", pre_ir1, 1'b0);
            if (pre_ir1 && iv1) item++;
            if (pre_ov1 && or1) got.push_back(pre_od1);
        end
        check("t5_count", got.size(), 10);
        for (int i = 0; i < got.size(); i++)
            check("t5_order", got[i], i);
        check("t5_cnt", cnt1, 16'd3);

        // T6: flush with skid full
        or1 = 0; iv1 = 1; idata1 = 32'hA;
        cycle();
        idata1 = 32'hB;
        cycle();
        check("t6_full", ir1, 1'b0);
        flush1 = 1; idata1 = 32'hC;
        cycle();
        check("t6_ov", ov1, 1'b0);
        check("t6_ir", ir1, 1'b1);
        flush1 = 0; or1 = 1; idata1 = 32'hD;
        cycle();
        check("t6_next_v", ov1, 1'b1);
        check("t6_next_d", od1, 32'hD);
        iv1 = 0;
        cycle();

        // long random run
        repeat (400) begin
            rand_inputs(1);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
